// File: rtl/snap_capture_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// snap_capture_ctrl
//
// Capture controller for the ADC snapshot path. A rising edge on the software
// arm bit clears the counters and arms the block; a hardware or software
// trigger then starts writing qualified samples into the snapshot BRAM until
// 2^ADDR_W words have been stored. The block also reports the number of
// words written (plus a done flag) and a saturating count of qualified
// sample cycles seen since the trigger, for the two status registers.
//
// Optional build macro: SNAP_CAPTURE_CTRL_DELAY_EN
//   Adds input trig_delay and a DELAY state that skips trig_delay qualified
//   cycles (the trigger cycle included) before writing starts.
//
// Ports:
//   user_clk     capture clock
//   user_rst     asynchronous active-high reset
//   ctrl_in      bit0 arm (rising edge), bit1 sw_trig, bit2 force_we
//   din / we     sample data and sample valid
//   trig         hardware trigger level
//   trig_delay   (optional) qualified cycles to skip after the trigger
//   bram_addr / bram_data / bram_we   registered BRAM write port
//   status_addr  {done, zeros, words_written[ADDR_W:0]}
//   tr_en_cnt    qualified cycles since trigger, zero-extended to 32 bits
//   done         capture complete
// ---------------------------------------------------------------------------
module snap_capture_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       ctrl_in,
  input  logic [DATA_W-1:0] din,
  input  logic              we,
  input  logic              trig,
`ifdef SNAP_CAPTURE_CTRL_DELAY_EN
  input  logic [31:0]       trig_delay,
`endif
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data,
  output logic              bram_we,
  output logic [31:0]       status_addr,
  output logic [31:0]       tr_en_cnt,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
`ifdef SNAP_CAPTURE_CTRL_DELAY_EN
    , S_DELAY
`endif
  } state_t;

  // words_written value just before the final write; the extra MSB of the
  // counter lets it reach exactly 2^ADDR_W without wrapping.
  localparam logic [ADDR_W:0] LAST_WORD = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] WW_ONE    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic                arm_prev_q;
  logic [ADDR_W:0]     ww_q, ww_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0]   bram_data_q, bram_data_d;
  logic                bram_we_q, bram_we_d;
`ifdef SNAP_CAPTURE_CTRL_DELAY_EN
  logic [31:0]         delay_q, delay_d;
`endif

  logic arm_edge, trig_eff, we_eff;
  logic do_write, cnt_inc;

  // Only the three defined control bits are used.
  logic unused_ctrl;
  assign unused_ctrl = ^ctrl_in[31:3];

  assign arm_edge = ctrl_in[0] & ~arm_prev_q;
  assign trig_eff = trig | ctrl_in[1];
  assign we_eff   = we | ctrl_in[2];

  // NOTE: every signal this block writes gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    ww_d        = ww_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    bram_addr_d = bram_addr_q;
    bram_data_d = bram_data_q;
    bram_we_d   = 1'b0;
    do_write    = 1'b0;
    cnt_inc     = 1'b0;
`ifdef SNAP_CAPTURE_CTRL_DELAY_EN
    delay_d     = delay_q;
`endif

    if (arm_edge) begin
      // Re-arm wins over everything else seen in the same cycle.
      state_d = S_ARMED;
      ww_d    = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (trig_eff) begin
`ifdef SNAP_CAPTURE_CTRL_DELAY_EN
            if (trig_delay != 32'd0) begin
              // The trigger-cycle sample is the first skipped sample.
              cnt_inc = we_eff;
              delay_d = trig_delay - {31'd0, we_eff};
              state_d = (delay_d == 32'd0) ? S_CAPTURE : S_DELAY;
            end else
`endif
            begin
              state_d  = S_CAPTURE;
              do_write = we_eff;
            end
          end
        end
`ifdef SNAP_CAPTURE_CTRL_DELAY_EN
        S_DELAY: begin
          if (we_eff) begin
            cnt_inc = 1'b1;
            delay_d = delay_q - 32'd1;
            if (delay_d == 32'd0) state_d = S_CAPTURE;
          end
        end
`endif
        S_CAPTURE: do_write = we_eff;
        S_DONE:    cnt_inc  = we_eff;
        default:   ;
      endcase
    end

    if (do_write) begin
      bram_data_d = din;
      bram_addr_d = ww_q[ADDR_W-1:0];
      bram_we_d   = 1'b1;
      ww_d        = ww_q + WW_ONE;
      cnt_inc     = 1'b1;
      if (ww_q == LAST_WORD) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
    end

    // Saturating qualified-cycle counter.
    if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_ONE;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values computed before this edge, independent of statement order.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q     <= S_IDLE;
      arm_prev_q  <= 1'b0;
      ww_q        <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      bram_addr_q <= '0;
      bram_data_q <= '0;
      bram_we_q   <= 1'b0;
`ifdef SNAP_CAPTURE_CTRL_DELAY_EN
      delay_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      arm_prev_q  <= ctrl_in[0];
      ww_q        <= ww_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      bram_addr_q <= bram_addr_d;
      bram_data_q <= bram_data_d;
      bram_we_q   <= bram_we_d;
`ifdef SNAP_CAPTURE_CTRL_DELAY_EN
      delay_q     <= delay_d;
`endif
    end
  end

  assign bram_addr = bram_addr_q;
  assign bram_data = bram_data_q;
  assign bram_we   = bram_we_q;
  assign done      = done_q;

  always_comb begin
    status_addr           = '0;
    status_addr[31]       = done_q;
    status_addr[ADDR_W:0] = ww_q;
  end

  always_comb begin
    tr_en_cnt            = '0;
    tr_en_cnt[CNT_W-1:0] = cnt_q;
  end

endmodule

// File: tb/tb_snap_capture_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for snap_capture_ctrl with a 16-word capture depth.
// Stimulus is applied on the falling edge; a small behavioural model pushes
// every expected BRAM write into a queue, and a monitor pops and compares
// each write it sees one step after the rising edge.
module tb_snap_capture_ctrl;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              user_clk = 1'b0;
  logic              user_rst = 1'b1;
  logic [31:0]       ctrl_in  = '0;
  logic [DATA_W-1:0] din      = '0;
  logic              we       = 1'b0;
  logic              trig     = 1'b0;
  logic [31:0]       trig_delay_tb = '0;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_data;
  logic              bram_we;
  logic [31:0]       status_addr;
  logic [31:0]       tr_en_cnt;
  logic              done;

  snap_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .user_clk    (user_clk),
    .user_rst    (user_rst),
    .ctrl_in     (ctrl_in),
    .din         (din),
    .we          (we),
    .trig        (trig),
`ifdef SNAP_CAPTURE_CTRL_DELAY_EN
    .trig_delay  (trig_delay_tb),
`endif
    .bram_addr   (bram_addr),
    .bram_data   (bram_data),
    .bram_we     (bram_we),
    .status_addr (status_addr),
    .tr_en_cnt   (tr_en_cnt),
    .done        (done)
  );

  always #5 user_clk = ~user_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  always @(posedge user_clk) begin
    #1;
    if (bram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {63'd0, bram_we}, 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {{(64-ADDR_W){1'b0}}, bram_addr}, {{(64-ADDR_W){1'b0}}, e.addr});
        check("wr_data", bram_data, e.data);
      end
    end
  end

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_ARMED, M_CAPTURE, M_DONE, M_DELAY} mstate_t;
  mstate_t m_state = M_IDLE;
  int      m_ww = 0;
  int      m_cnt = 0;
  int      m_rem = 0;
  logic    m_arm_prev = 1'b0;
  int      cyc = 0;

  task automatic model_write(input logic [DATA_W-1:0] d);
    wr_t e;
    e.addr = m_ww[ADDR_W-1:0];
    e.data = d;
    exp_q.push_back(e);
    m_ww++;
    m_cnt++;
    if (m_ww == DEPTH) m_state = M_DONE;
  endtask

  // Drive one cycle of inputs on the falling edge and advance the model to
  // what the following rising edge should do.
  task automatic step(input logic [31:0] c, input logic w, input logic t);
    logic arm_e, we_e, tr_e;
    @(negedge user_clk);
    ctrl_in = c;
    we      = w;
    trig    = t;
    din     = {32'hD00D_0000, cyc[31:0]};
    cyc++;
    arm_e = c[0] & ~m_arm_prev;
    m_arm_prev = c[0];
    we_e = w | c[2];
    tr_e = t | c[1];
    if (arm_e) begin
      m_state = M_ARMED;
      m_ww    = 0;
      m_cnt   = 0;
    end else begin
      case (m_state)
        M_ARMED: if (tr_e) begin
          if (trig_delay_tb != 0) begin
            m_rem = int'(trig_delay_tb) - (we_e ? 1 : 0);
            if (we_e) m_cnt++;
            m_state = (m_rem == 0) ? M_CAPTURE : M_DELAY;
          end else begin
            m_state = M_CAPTURE;
            if (we_e) model_write(din);
          end
        end
        M_DELAY: if (we_e) begin
          m_cnt++;
          m_rem--;
          if (m_rem == 0) m_state = M_CAPTURE;
        end
        M_CAPTURE: if (we_e) model_write(din);
        M_DONE:    if (we_e) m_cnt++;
        default: ;
      endcase
    end
  endtask

  // Move to just after the next rising edge (after the monitor has run).
  task automatic wait_edge();
    @(posedge user_clk);
    #2;
  endtask

  task automatic check_status(input string tag, input logic [31:0] exp_status,
                              input logic [31:0] exp_cnt, input logic exp_done);
    check({tag, "_status"}, {32'd0, status_addr}, {32'd0, exp_status});
    check({tag, "_cnt"}, {32'd0, tr_en_cnt}, {32'd0, exp_cnt});
    check({tag, "_done"}, {63'd0, done}, {63'd0, exp_done});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state ----
    #12;
    check_status("in_reset", 32'h0, 32'd0, 1'b0);
    check("in_reset_we", {63'd0, bram_we}, 64'd0);
    @(negedge user_clk);
    user_rst = 1'b0;
    wait_edge();
    check_status("after_reset", 32'h0, 32'd0, 1'b0);
    check("after_reset_addr", {60'd0, bram_addr}, 64'd0);
    check("after_reset_data", bram_data, 64'd0);

    // ---- idle: trig and we without arm do nothing ----
    for (int i = 0; i < 20; i++) step(32'h0, 1'b1, 1'b1);
    wait_edge();
    check_status("idle_ignore", 32'h0, 32'd0, 1'b0);
    check("idle_we", {63'd0, bram_we}, 64'd0);

    // ---- full capture with continuous we ----
    step(32'h1, 1'b1, 1'b0);              // arm edge, we ignored
    wait_edge();
    check_status("armed", 32'h0, 32'd0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      step(32'h0, 1'b1, (i == 0));
      wait_edge();
      if (i == DEPTH - 2) check_status("fill_15", 32'h0000_000F, 32'd15, 1'b0);
    end
    check_status("full", 32'h8000_0010, 32'd16, 1'b1);
    for (int i = 0; i < 4; i++) step(32'h0, 1'b1, 1'b0);
    wait_edge();
    check_status("overrun", 32'h8000_0010, 32'd20, 1'b1);
    check("overrun_we", {63'd0, bram_we}, 64'd0);

    // ---- we toggling ----
    step(32'h1, 1'b0, 1'b0);
    wait_edge();
    check_status("rearm_done", 32'h0, 32'd0, 1'b0);
    step(32'h0, 1'b1, 1'b1);
    for (int i = 1; i < 20; i++) step(32'h0, (i % 2 == 0), 1'b0);
    wait_edge();
    check_status("toggle", 32'h0000_000A, 32'd10, 1'b0);

    // ---- software trigger and forced we ----
    step(32'h6, 1'b0, 1'b0);              // force_we still writes in CAPTURE
    step(32'h7, 1'b0, 1'b0);              // arm edge
    wait_edge();
    check_status("sw_armed", 32'h0, 32'd0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(32'h7, 1'b0, 1'b0);
    wait_edge();
    check_status("sw_full", 32'h8000_0010, 32'd16, 1'b1);
    step(32'h6, 1'b0, 1'b0);

    // ---- arm coincident with trig and we, then re-arm mid capture ----
    step(32'h1, 1'b1, 1'b1);
    wait_edge();
    check_status("arm_coinc", 32'h0, 32'd0, 1'b0);
    check("arm_coinc_we", {63'd0, bram_we}, 64'd0);
    step(32'h0, 1'b1, 1'b1);
    for (int i = 1; i < 7; i++) step(32'h0, 1'b1, 1'b0);
    wait_edge();
    check_status("seven", 32'h0000_0007, 32'd7, 1'b0);
    step(32'h1, 1'b1, 1'b0);
    wait_edge();
    check_status("rearm_mid", 32'h0, 32'd0, 1'b0);
    step(32'h0, 1'b1, 1'b1);
    for (int i = 1; i < 5; i++) step(32'h0, 1'b1, 1'b0);
    wait_edge();
    check_status("five", 32'h0000_0005, 32'd5, 1'b0);

    // ---- asynchronous reset between edges ----
    #1;
    user_rst = 1'b1;
    #1;
    check_status("async_rst", 32'h0, 32'd0, 1'b0);
    check("async_rst_we", {63'd0, bram_we}, 64'd0);
    check("async_rst_addr", {60'd0, bram_addr}, 64'd0);
    m_state = M_IDLE;
    m_ww = 0;
    m_cnt = 0;
    m_arm_prev = 1'b0;
    @(negedge user_clk);
    user_rst = 1'b0;
    for (int i = 0; i < 5; i++) step(32'h0, 1'b1, 1'b1);
    wait_edge();
    check_status("post_rst_trig", 32'h0, 32'd0, 1'b0);

`ifdef SNAP_CAPTURE_CTRL_DELAY_EN
    // ---- delayed start ----
    trig_delay_tb = 32'd3;
    step(32'h1, 1'b0, 1'b0);
    step(32'h0, 1'b1, 1'b1);
    for (int i = 1; i < 3; i++) step(32'h0, 1'b1, 1'b0);
    wait_edge();
    check_status("delay_skip", 32'h0, 32'd3, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(32'h0, 1'b1, 1'b0);
    wait_edge();
    check_status("delay_full", 32'h8000_0010, 32'd19, 1'b1);
`endif

    step(32'h0, 1'b0, 1'b0);
    wait_edge();
    check("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/snap_capture_ctrl.md
Name: snap_capture_ctrl

Overview:
- Capture controller for the ADC snapshot path. It arms from a software control word, waits for a trigger, then writes qualified ADC samples into the snapshot BRAM.
- Produces the write-address/done status word and the trigger-enable count word.
- The count word drives the user_data_in of the tr_en_cnt simulink2ppc status register. The address/done word drives the companion status register.
- Runs entirely in the user_clk domain, between the ADC data path and the snapshot BRAM/status registers.

Parameters:
ADDR_W, 11, BRAM address width; capture depth = 2^ADDR_W words
DATA_W, 64, sample/BRAM data width
CNT_W, 32, width of tr_en_cnt counter (<= 32, zero-extended onto tr_en_cnt output)

Ports:
user_clk  in  1  capture clock (ADC-derived user clock)
user_rst  in  1  asynchronous active-high reset
ctrl_in  in  32  from ppc2simulink ctrl register: bit0 arm (rising-edge), bit1 sw_trig, bit2 force_we; others ignored
din  in  DATA_W  sample data
we  in  1  sample valid / write enable
trig  in  1  hardware trigger, level, sampled each cycle
bram_addr  out  ADDR_W  BRAM write address
bram_data  out  DATA_W  BRAM write data
bram_we  out  1  BRAM write strobe
status_addr  out  32  {done, zeros, words_written[ADDR_W:0]} to status register
tr_en_cnt  out  32  qualified-write cycles since trigger, zero-extended
done  out  1  capture complete

Behaviour:
- Reset (async, user_rst=1): state IDLE; bram_addr=0, bram_data=0, bram_we=0, status_addr=0, tr_en_cnt=0, done=0, arm_prev=0. Reset mid-capture aborts the capture with no further writes.
- arm_edge = ctrl_in[0] & ~arm_prev; arm_prev registered every cycle.
- trig_eff = trig | ctrl_in[1].
- we_eff = we | ctrl_in[2].
- States:
  - IDLE: wait for arm_edge.
  - ARMED: counters cleared; wait for trig_eff.
  - CAPTURE: writing.
  - DONE: full.
- arm_edge in any state:
  - next state ARMED; words_written=0, tr_en_cnt=0, done=0.
  - Highest priority. Trig or we in the same cycle is ignored.
- ARMED and trig_eff=1: next state CAPTURE. If we_eff=1 that same cycle, the sample is written (trigger cycle is sample 0).
- CAPTURE and we_eff=1:
  - bram_data<=din, bram_addr<=words_written[ADDR_W-1:0], bram_we<=1, words_written++.
  - All BRAM outputs are registered: 1-cycle latency from din/we to bram_*.
- CAPTURE and we_eff=0: bram_we<=0, no address change.
- Last write: the write that makes words_written = 2^ADDR_W moves to DONE and sets done<=1 in the same edge as that bram_we. The address never wraps; no overwrite.
- DONE: bram_we=0; further we_eff and trig are ignored for writes. done holds until arm_edge or reset.
- tr_en_cnt:
  - Increments on every we_eff cycle in CAPTURE and DONE, including the trigger cycle.
  - Saturates at 2^CNT_W-1; holds in IDLE/ARMED.
  - Exceeds 2^ADDR_W when data kept arriving after full; software uses this as an overrun indicator.
- status_addr: bit31=done, bits[ADDR_W:0]=words_written. Updated on the same edge as the corresponding bram_we.
- trig in CAPTURE/DONE: ignored (no retrigger without re-arm).
- ctrl_in[0] held high: only one arm per rising edge.

Optional Feature:
- Macro SNAP_CAPTURE_CTRL_DELAY_EN.
- When defined:
  - Adds input trig_delay [31:0].
  - After trig_eff in ARMED, enters DELAY state and skips trig_delay we_eff cycles before CAPTURE. The trigger-cycle sample counts as skip #1 when trig_delay>0.
  - Skipped cycles do increment tr_en_cnt.
  - trig_delay=0 behaves exactly as without the macro.
  - arm_edge during DELAY re-arms.
- When undefined: no port, no DELAY state; behaviour as above.

Test Plan:
- Reset release, ADDR_W=4: all outputs 0, state IDLE; we=1, trig=1 for 20 cycles -> bram_we never 1, tr_en_cnt=0.
- Arm edge, trig pulse with we=1 continuous, din=cycle index:
  - 16 writes, addresses 0..15, data matches 1 cycle earlier.
  - done=1 with 16th write; status_addr=0x80000010.
  - 4 more we cycles -> tr_en_cnt=20, bram_we=0.
- Arm, trig, we toggling 1/0: writes only on we=1 cycles, addresses contiguous. After 10 we cycles: status_addr=0x0000000A, tr_en_cnt=10, done=0.
- ctrl_in=0x6 (sw_trig, force_we) then arm edge with trig=0 and we=0: capture starts next cycle, 16 consecutive writes, done after 16.
- Arm edge coincident with trig=1 and we=1: no write that cycle, state ARMED. Trig next cycle -> capture starts. Re-arm mid-capture at 7 words -> status_addr=0, tr_en_cnt=0, next trig writes from address 0.
- user_rst asserted mid-capture at 5 words (asynchronously, between edges): outputs 0 immediately. After release, trig without arm produces no writes.
- With SNAP_CAPTURE_CTRL_DELAY_EN, trig_delay=3, we=1:
  - First write is the 4th we cycle after trigger, at address 0.
  - tr_en_cnt=19 when done.
